reflet_bus_arbiter: RTL
=======================

REFLET_BUS_ARBITER -- requirements
Module: reflet_bus_arbiter

Interface
REQ-001 Parameter wordsize, default 16: width of address and data words.
REQ-002 Parameter latency, default 2: bus cycles held per transaction, legal range 1..255.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 m0_req / m1_req  input  1  requester wants one bus transaction.
REQ-006 m0_we / m1_we  input  1  transaction is a write when high.
REQ-007 m0_addr / m1_addr  input  wordsize  transaction address.
REQ-008 m0_wdata / m1_wdata  input  wordsize  write data.
REQ-009 m0_ack / m1_ack  output  1  one-cycle completion pulse.
REQ-010 m0_rdata / m1_rdata  output  wordsize  registered read data, valid while ack high, held afterwards.
REQ-011 addr  output  wordsize  shared system bus address.
REQ-012 data_out  output  wordsize  shared system bus write data.
REQ-013 write_en  output  1  shared system bus write strobe.
REQ-014 data_in  input  wordsize  shared system bus read data.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States: IDLE, ACCESS, ACK; one transaction in flight at a time.
REQ-017 IDLE: on a clock edge with any req high, choose winner, latch its addr/wdata/we into internal registers, load counter with latency-1, go ACCESS.
REQ-018 IDLE with both req low: stay IDLE, no state change.
REQ-019 ACCESS: addr/data_out/write_en driven from latched registers; counter decrements each cycle; at counter==0, capture data_in into winner's rdata, go ACK.
REQ-020 Outside ACCESS: addr=0, data_out=0, write_en=0.
REQ-021 ACK: winner's ack high exactly one cycle, loser's ack low; next state IDLE unconditionally.
REQ-022 Requests ignored in ACCESS and ACK; a requester drops req on the edge ending its ack cycle, else a new transaction starts.
REQ-023 Timing: req sampled at edge N -> ACCESS cycles N+1..N+latency -> ack high in cycle N+latency+1.
REQ-024 latency=1: single ACCESS cycle, no wrap of counter.
REQ-025 Inputs changing during ACCESS have no effect on the bus; latched values rule.
REQ-026 Write transactions also capture data_in into rdata; value is don't-care to requester.
REQ-027 Loser's rdata unchanged by a transaction it did not win.

Reset
REQ-028 reset low: immediately state=IDLE, counter=0, acks=0, rdata=0, addr/data_out/write_en=0, busy=0, last-grant=master 1.
REQ-029 Reset mid-ACCESS aborts transaction; no ack ever issued for it; first req after release re-arbitrates.

Configuration
REQ-030 Macro REFLET_ARB_ROUND_ROBIN_EN defined: tie (both req in IDLE) goes to master not granted last; last-grant register updated on every grant.
REQ-031 Macro undefined: tie always goes to master 0; last-grant register absent; single-requester behaviour identical.

Verification
REQ-032 latency=2, m0 read addr 0x0040, data_in=0xBEEF -> addr=0x0040 two cycles, m0_ack cycle 3, m0_rdata=0xBEEF.
REQ-033 m1 write addr 0x0100 data 0x1234 -> write_en=1, data_out=0x1234 for 2 cycles, m1_ack after, m0_ack stays 0.
REQ-034 Both req held continuously, RR enabled -> grants m0,m1,m0,m1; RR disabled -> m0 every transaction, m1 starved.
REQ-035 m0 changes addr to 0x0FFF during ACCESS -> bus addr stays latched 0x0040.
REQ-036 reset pulled low in first ACCESS cycle -> bus outputs 0 same cycle, no ack, busy=0; after release m1 req served normally.
REQ-037 latency=1, back-to-back m0 requests -> ack every 3 cycles, busy low one cycle between.

Source files
------------

// File: rtl/reflet_bus_arbiter_if.sv
// rtl/reflet_bus_arbiter_if.sv - two-requester bus arbiter handshake and shared system bus signals
interface reflet_bus_arbiter_if #(
    parameter int wordsize = 16
);
    logic                m0_req;
    logic                m0_we;
    logic [wordsize-1:0] m0_addr;
    logic [wordsize-1:0] m0_wdata;
    logic                m0_ack;
    logic [wordsize-1:0] m0_rdata;

    logic                m1_req;
    logic                m1_we;
    logic [wordsize-1:0] m1_addr;
    logic [wordsize-1:0] m1_wdata;
    logic                m1_ack;
    logic [wordsize-1:0] m1_rdata;

    logic [wordsize-1:0] addr;
    logic [wordsize-1:0] data_out;
    logic                write_en;
    logic [wordsize-1:0] data_in;
    logic                busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        input  data_in,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output addr, data_out, write_en, busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        output data_in,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  addr, data_out, write_en, busy
    );
endinterface

// File: rtl/reflet_bus_arbiter.sv
// rtl/reflet_bus_arbiter.sv - two-master bus arbiter, IDLE/ACCESS/ACK FSM; REFLET_ARB_ROUND_ROBIN_EN enables round-robin ties
module reflet_bus_arbiter #(
    parameter int wordsize = 16,
    parameter int latency  = 2
) (
    input logic                   clk,
    input logic                   reset,
    reflet_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t     state;
    logic [7:0] count;
    logic       winner;
    logic       pick_m1;

`ifdef REFLET_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie, favour whichever master was not granted last.
    always_comb begin
        pick_m1 = 1'b0;
        if (bus.m0_req && bus.m1_req)
            pick_m1 = ~last_grant;
        else
            pick_m1 = bus.m1_req;
    end
`else
    always_comb begin
        pick_m1 = 1'b0;
        if (!bus.m0_req)
            pick_m1 = bus.m1_req;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            count        <= 8'd0;
            winner       <= 1'b0;
            bus.m0_ack   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_rdata <= '0;
            bus.addr     <= '0;
            bus.data_out <= '0;
            bus.write_en <= 1'b0;
            bus.busy     <= 1'b0;
`ifdef REFLET_ARB_ROUND_ROBIN_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        winner       <= pick_m1;
                        bus.addr     <= pick_m1 ? bus.m1_addr  : bus.m0_addr;
                        bus.data_out <= pick_m1 ? bus.m1_wdata : bus.m0_wdata;
                        bus.write_en <= pick_m1 ? bus.m1_we    : bus.m0_we;
                        count        <= 8'(latency - 1);
                        state        <= ACCESS;
                        bus.busy     <= 1'b1;
`ifdef REFLET_ARB_ROUND_ROBIN_EN
                        last_grant   <= pick_m1;
`endif
                    end
                end
                ACCESS: begin
                    // The bus registers double as the transaction latches, so
                    // they hold steady until the last access cycle ends.
                    if (count == 8'd0) begin
                        if (winner) begin
                            bus.m1_rdata <= bus.data_in;
                            bus.m1_ack   <= 1'b1;
                        end else begin
                            bus.m0_rdata <= bus.data_in;
                            bus.m0_ack   <= 1'b1;
                        end
                        bus.addr     <= '0;
                        bus.data_out <= '0;
                        bus.write_en <= 1'b0;
                        state        <= ACK;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
